// File: rtl/scan_cmd_ctrl.sv
// scan_cmd_ctrl: UART command controller driving scan chains, clocking and reset of a part under test
module scan_cmd_ctrl #(
    parameter int NCHAINS    = 1,
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 4,
    parameter bit ACK_EN     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    output logic               part_clk,
    output logic               part_rstn,
    output logic               part_se,
    output logic               part_tm,
    output logic [NCHAINS-1:0] scan_in,
    input  logic [NCHAINS-1:0] scan_out,
    output logic               busy
);
    typedef enum logic [3:0] {
        IDLE, CNT, SET_COL, GET_SEND, SHIFT_HI, SHIFT_LO, EXEC_HI, EXEC_LO, RST_HOLD, ACK, ERR
    } state_t;
    localparam int NB = CNT_W / 8;
    state_t state, state_n, done_st;
    logic [7:0] cmd, cmd_n, idx, idx_n, tx_byte, tx_data_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [NCHAINS-1:0] samp, samp_n, sel, scan_in_n;
    logic [31:0] rcnt, rcnt_n;
    logic tx_start_n, part_clk_n, part_rstn_n, part_se_n;
    logic tx_go, tx_done, is_bit, is_p;
    assign busy = state != IDLE;
    assign part_tm = 1'b1;
    always_comb begin
        state_n = state;
        cmd_n = cmd;
        idx_n = idx;
        cnt_n = cnt;
        samp_n = samp;
        rcnt_n = rcnt;
        tx_start_n = tx_start;
        tx_data_n = tx_data;
        part_clk_n = part_clk;
        part_rstn_n = part_rstn;
        part_se_n = part_se;
        scan_in_n = scan_in;
        done_st = ACK_EN ? ACK : IDLE;
        is_bit = rx_data == 8'h30 || rx_data == 8'h31;
        is_p = rx_valid && rx_data == "p";
        sel = samp >> idx;
        tx_byte = state == ACK ? 8'h2E : state == ERR ? 8'h3F : sel[0] ? 8'h31 : 8'h30;
        tx_go = !tx_start && tx_ready && (state == GET_SEND || state == ACK || state == ERR);
        tx_done = tx_start && !tx_ready;
        if (tx_go) begin
            tx_start_n = 1'b1;
            tx_data_n = tx_byte;
        end
        if (tx_done)
            tx_start_n = 1'b0;
        case (state)
            IDLE: if (rx_valid) begin
                cmd_n = rx_data;
                idx_n = '0;
                if (rx_data == "r") begin
                    state_n = RST_HOLD;
                    part_rstn_n = 1'b0;
                    rcnt_n = '0;
                end else if (rx_data inside {"s", "g", "e"})
                    state_n = CNT;
                else if (rx_data == "f")
                    state_n = EXEC_HI;
            end
            CNT: if (rx_valid) begin
                cnt_n = CNT_W'({cnt, rx_data});
                idx_n = idx + 8'd1;
                if (idx == 8'(NB - 1)) begin
                    idx_n = '0;
                    samp_n = scan_out;
                    state_n = cnt_n == '0 ? done_st : cmd == "s" ? SET_COL : cmd == "g" ? GET_SEND : EXEC_HI;
                end
            end
            SET_COL: if (rx_valid) begin
                if (!is_bit) begin
                    state_n = ERR;
                    part_se_n = 1'b0;
                end else begin
                    scan_in_n = (scan_in & ~(NCHAINS'(1) << idx)) | (NCHAINS'(rx_data[0]) << idx);
                    part_se_n = 1'b1;
                    idx_n = idx + 8'd1;
                    if (idx == 8'(NCHAINS - 1)) begin
                        idx_n = '0;
                        state_n = SHIFT_HI;
                    end
                end
            end
            GET_SEND: if (tx_done) begin
                idx_n = idx + 8'd1;
                if (idx == 8'(NCHAINS - 1)) begin
                    idx_n = '0;
                    part_se_n = 1'b1;
                    scan_in_n = '0;
                    state_n = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                part_clk_n = 1'b1;
                state_n = SHIFT_LO;
            end
            SHIFT_LO: begin
                part_clk_n = 1'b0;
                cnt_n = cnt - CNT_W'(1);
                // chain outputs are captured on the falling edge, stable until the next rise
                samp_n = scan_out;
                if (cnt == CNT_W'(1)) begin
                    part_se_n = 1'b0;
                    state_n = done_st;
                end else
                    state_n = cmd == "s" ? SET_COL : GET_SEND;
            end
            EXEC_HI: if (is_p)
                state_n = done_st;
            else begin
                part_clk_n = 1'b1;
                state_n = EXEC_LO;
            end
            EXEC_LO: begin
                part_clk_n = 1'b0;
                if (cmd != "f")
                    cnt_n = cnt - CNT_W'(1);
                state_n = is_p || (cmd != "f" && cnt == CNT_W'(1)) ? done_st : EXEC_HI;
            end
            RST_HOLD: begin
                rcnt_n = rcnt + 32'd1;
                if (rcnt == 32'(RST_CYCLES - 1)) begin
                    part_rstn_n = 1'b1;
                    state_n = done_st;
                end
            end
            ACK, ERR: if (tx_done)
                state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cmd <= '0;
            idx <= '0;
            cnt <= '0;
            samp <= '0;
            rcnt <= '0;
            tx_start <= 1'b0;
            tx_data <= '0;
            part_clk <= 1'b0;
            part_rstn <= 1'b1;
            part_se <= 1'b0;
            scan_in <= '0;
        end else begin
            state <= state_n;
            cmd <= cmd_n;
            idx <= idx_n;
            cnt <= cnt_n;
            samp <= samp_n;
            rcnt <= rcnt_n;
            tx_start <= tx_start_n;
            tx_data <= tx_data_n;
            part_clk <= part_clk_n;
            part_rstn <= part_rstn_n;
            part_se <= part_se_n;
            scan_in <= scan_in_n;
        end
    end
endmodule
